// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv
// Description : Multicycle execute unit. Base ALU ops finish in one cycle;
//               RV32M mul/div/rem run on an iterative shift-add / restoring
//               engine behind a start/done handshake. Optional build macro
//               MULDIV_EARLY_OUT_EN skips the engine for trivial operands.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      control,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    localparam int c_ITER  = XLEN / UNROLL;
    localparam int c_CNT_W = (c_ITER > 1) ? $clog2(c_ITER) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_ITER - 1);
    localparam logic [XLEN-1:0]    c_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [3:0] c_OP_AND    = 4'b0000;
    localparam logic [3:0] c_OP_OR     = 4'b0001;
    localparam logic [3:0] c_OP_ADD    = 4'b0010;
    localparam logic [3:0] c_OP_SUB    = 4'b0110;
    localparam logic [3:0] c_OP_MUL    = 4'b1000;
    localparam logic [3:0] c_OP_MULH   = 4'b1001;
    localparam logic [3:0] c_OP_MULHSU = 4'b1010;
    localparam logic [3:0] c_OP_MULHU  = 4'b1011;
    localparam logic [3:0] c_OP_DIV    = 4'b1100;
    localparam logic [3:0] c_OP_DIVU   = 4'b1101;
    localparam logic [3:0] c_OP_REM    = 4'b1110;
    localparam logic [3:0] c_OP_REMU   = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [XLEN-1:0]    r_result;
    logic               r_zero;
    logic [3:0]         r_op;
    logic               r_neg;
    logic               r_neg_a;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic [XLEN-1:0]    r_opb;
    logic [c_CNT_W-1:0] r_cnt;

    logic [XLEN-1:0]    w_base_res;
    logic               w_a_sgn;
    logic               w_b_sgn;
    logic [XLEN-1:0]    w_a_mag;
    logic [XLEN-1:0]    w_b_mag;
    logic               w_early;
    logic [XLEN-1:0]    w_early_res;
    logic [XLEN-1:0]    w_hi_nx;
    logic [XLEN-1:0]    w_lo_nx;
    logic [XLEN:0]      w_trial;
    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_quo;
    logic [XLEN-1:0]    w_rem;
    logic [XLEN-1:0]    w_fix_res;

    always_comb begin
        w_base_res = '0;
        case (control)
            c_OP_AND: w_base_res = A & B;
            c_OP_OR:  w_base_res = A | B;
            c_OP_ADD: w_base_res = A + B;
            c_OP_SUB: w_base_res = A - B;
            default:  w_base_res = '0;
        endcase
    end

    // The engine works on magnitudes; MUL is taken as unsigned since its low half is sign-agnostic.
    assign w_a_sgn = A[XLEN-1] & ((control == c_OP_MULH) | (control == c_OP_MULHSU) |
                                  (control == c_OP_DIV)  | (control == c_OP_REM));
    assign w_b_sgn = B[XLEN-1] & ((control == c_OP_MULH) | (control == c_OP_DIV) |
                                  (control == c_OP_REM));
    assign w_a_mag = w_a_sgn ? -A : A;
    assign w_b_mag = w_b_sgn ? -B : B;

`ifdef MULDIV_EARLY_OUT_EN
    always_comb begin
        w_early     = 1'b0;
        w_early_res = '0;
        if (!control[2]) begin
            w_early = (A == '0) || (B == '0);
        end else if (B == '0) begin
            w_early     = 1'b1;
            w_early_res = control[1] ? A : '1;
        end else if (!control[0] && (A == c_MIN) && (B == '1)) begin
            w_early     = 1'b1;
            w_early_res = control[1] ? '0 : A;
        end
    end
`else
    assign w_early     = 1'b0;
    assign w_early_res = '0;
`endif

    // One engine step per unrolled bit: restoring divide shifts the dividend out of r_lo
    // into the remainder in r_hi; shift-add multiply shifts the product right through r_hi:r_lo.
    always_comb begin
        w_hi_nx = r_hi;
        w_lo_nx = r_lo;
        w_trial = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (r_op[2]) begin
                w_trial = {w_hi_nx, w_lo_nx[XLEN-1]};
                w_lo_nx = {w_lo_nx[XLEN-2:0], 1'b0};
                if (w_trial >= {1'b0, r_opb}) begin
                    w_trial    = w_trial - {1'b0, r_opb};
                    w_lo_nx[0] = 1'b1;
                end
                w_hi_nx = w_trial[XLEN-1:0];
            end else begin
                w_trial = {1'b0, w_hi_nx} + (w_lo_nx[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
                w_lo_nx = {w_trial[0], w_lo_nx[XLEN-1:1]};
                w_hi_nx = w_trial[XLEN:1];
            end
        end
    end

    assign w_prod = r_neg   ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quo  = r_neg   ? -r_lo : r_lo;
    assign w_rem  = r_neg_a ? -r_hi : r_hi;

    always_comb begin
        w_fix_res = '0;
        case (r_op)
            c_OP_MUL:                           w_fix_res = w_prod[XLEN-1:0];
            c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
            c_OP_DIV, c_OP_DIVU:                w_fix_res = w_quo;
            c_OP_REM, c_OP_REMU:                w_fix_res = w_rem;
            default:                            w_fix_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (!control[3]) begin
                            r_result <= w_base_res;
                            r_zero   <= (w_base_res == '0);
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (w_early) begin
                            r_result <= w_early_res;
                            r_zero   <= (w_early_res == '0);
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_op    <= control;
                            r_neg   <= (w_a_sgn ^ w_b_sgn) & (B != '0);
                            r_neg_a <= w_a_sgn;
                            r_hi    <= '0;
                            r_lo    <= w_a_mag;
                            r_opb   <= w_b_mag;
                            r_cnt   <= '0;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_zero   <= (w_fix_res == '0);
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign zero   = r_zero;

endmodule
`default_nettype wire
